// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared types and constants for the two-master instruction ROM fetch arbiter.
package rom_fetch_arbiter_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam inst_t ZeroWord    = 32'h0000_0000;
  localparam logic  ChipEnable  = 1'b1;
  localparam logic  ChipDisable = 1'b0;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } arb_state_e;

  function automatic logic is_misaligned(input inst_addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rom_fetch_arbiter_if.sv
// Bundle of both master handshakes, the ROM port and arbiter status.
interface rom_fetch_arbiter_if;

  logic                             m0_req;
  rom_fetch_arbiter_pkg::inst_addr_t m0_addr;
  rom_fetch_arbiter_pkg::inst_t      m0_data;
  logic                             m0_ack;
  logic                             m1_req;
  rom_fetch_arbiter_pkg::inst_addr_t m1_addr;
  rom_fetch_arbiter_pkg::inst_t      m1_data;
  logic                             m1_ack;
  logic                             err;
  logic                             rom_ce;
  rom_fetch_arbiter_pkg::inst_addr_t rom_addr;
  rom_fetch_arbiter_pkg::inst_t      rom_inst;
  logic                             rom_ack;
  logic                             grant_id;
  logic                             busy;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, rom_inst, rom_ack,
    output m0_data, m0_ack, m1_data, m1_ack, err, rom_ce, rom_addr, grant_id, busy
  );

  // Environment side: masters plus the ROM.
  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, rom_inst, rom_ack,
    input  m0_data, m0_ack, m1_data, m1_ack, err, rom_ce, rom_addr, grant_id, busy
  );

endinterface

// File: rtl/rom_fetch_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the master that did not win last time wins.
module rom_fetch_arbiter_rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares one ROM port between fetch (m0) and data-side (m1) masters with wait states,
// timeout and registered single-cycle ack pulses.
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned CNT_W       = 4
) (
  input logic                    clk,
  input logic                    rst,
  rom_fetch_arbiter_if.slave     bus
);

  localparam logic [CNT_W-1:0] WaitLoad    = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q;
  logic             last_grant_q;
  logic             grant_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] tcnt_q;
  logic             rom_ce_q;
  inst_addr_t       rom_addr_q;
  inst_t            m0_data_q, m1_data_q;
  logic             m0_ack_q, m1_ack_q, err_q, busy_q;

  logic       arb_valid, arb_grant;
  inst_addr_t sel_addr;
  logic       idle_grant, rom_done, timeout_hit, resp_go, resp_id;
  inst_t      resp_data;

  rom_fetch_arbiter_rr_arbiter2 u_rr (
    .req        ({bus.m1_req, bus.m0_req}),
    .last_grant (last_grant_q),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  always_comb begin
    sel_addr    = arb_grant ? bus.m1_addr : bus.m0_addr;
    idle_grant  = (state_q == StIdle) && arb_valid;
    rom_done    = (state_q == StAccess) && (cnt_q == '0) && bus.rom_ack;
    timeout_hit = (state_q == StAccess) && (cnt_q == '0) && !bus.rom_ack &&
                  (tcnt_q == TimeoutLast);
    // Misaligned grants skip the ROM and respond with an error straight away.
    resp_go     = (idle_grant && is_misaligned(sel_addr)) || rom_done || timeout_hit;
    resp_id     = (state_q == StIdle) ? arb_grant : grant_q;
    resp_data   = rom_done ? bus.rom_inst : ZeroWord;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      rom_ce_q     <= ChipDisable;
      rom_addr_q   <= ZeroWord;
      m0_data_q    <= ZeroWord;
      m1_data_q    <= ZeroWord;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_grant) begin
            grant_q      <= arb_grant;
            last_grant_q <= arb_grant;
            rom_addr_q   <= sel_addr;
            cnt_q        <= WaitLoad;
            tcnt_q       <= '0;
            busy_q       <= 1'b1;
            state_q      <= StAccess;
            rom_ce_q     <= ChipEnable;
          end
        end
        StAccess: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!bus.rom_ack && tcnt_q != TimeoutLast) begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        StResp: begin
          state_q  <= StIdle;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
          err_q    <= 1'b0;
          busy_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      // Overrides the IDLE/ACCESS defaults above when the access completes this cycle.
      if (resp_go) begin
        state_q  <= StResp;
        rom_ce_q <= ChipDisable;
        err_q    <= !rom_done;
        if (resp_id) begin
          m1_ack_q  <= 1'b1;
          m1_data_q <= resp_data;
        end else begin
          m0_ack_q  <= 1'b1;
          m0_data_q <= resp_data;
        end
      end
    end
  end

  assign bus.m0_data  = m0_data_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_data  = m1_data_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.err      = err_q;
  assign bus.rom_ce   = rom_ce_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/rom_fetch_arbiter.md
Name: rom_fetch_arbiter

Overview:
- Shares the single instruction ROM port (ce/addr → inst/ack) between two masters:
  - m0: instruction fetch.
  - m1: data-side load of ROM constants.
- Round-robin arbitration, one outstanding access at a time.
- Programmable wait states and a timeout.
- Responses are registered, so masters see a single-cycle ack pulse with data held stable.

Parameters:
- WAIT_CYCLES, 0, extra cycles held in ACCESS before rom_ack is sampled (0..14).
- TIMEOUT, 15, maximum cycles in ACCESS, after the wait states, before an error response (1..15).
- CNT_W, 4, width of the wait/timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- m0_req  in  1  fetch request; held with m0_addr until m0_ack.
- m0_addr  in  32  fetch byte address (`InstAddrBus).
- m0_data  out  32  fetch read data (`InstBus).
- m0_ack  out  1  one-cycle response pulse.
- m1_req, m1_addr, m1_data, m1_ack  same as m0, for the data side.
- err  out  1  pulses with mX_ack on a misaligned or timed-out access.
- rom_ce  out  1  ROM chip enable (`ChipEnable/`ChipDisable).
- rom_addr  out  32  ROM address.
- rom_inst  in  32  ROM read data.
- rom_ack  in  1  ROM acknowledge (combinational from rom_ce).
- grant_id  out  1  master owning the current access.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_grant=1 (so m0 wins first).
  - All outputs 0; rom_ce=`ChipDisable, data registers=`ZeroWord.
  - Reset mid-access abandons the access; no ack is issued.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the master != last_grant.
  - On grant: latch addr and grant_id, update last_grant, cnt=WAIT_CYCLES.
  - If addr[1:0]!=0 (misaligned): go directly to RESP with data=`ZeroWord and err=1; rom_ce stays low.
  - Otherwise: go to ACCESS, rom_ce=1, rom_addr=latched addr.
- ACCESS:
  - While cnt>0: decrement cnt.
  - When cnt==0 and rom_ack=1: capture rom_inst into the granted master's data register, rom_ce=0, go to RESP, assert that master's ack.
  - When cnt==0 and rom_ack=0: count the timeout. After TIMEOUT such cycles, go to RESP with data=`ZeroWord and err=1.
  - The timeout counter is separate or reloaded with TIMEOUT on wait expiry; it saturates and does not wrap.
- RESP:
  - mX_ack (and err if set) is high for exactly this cycle.
  - Next edge: go to IDLE and clear ack/err.
  - mX_data holds its value until the next access to the same master.
  - The other master's ack stays 0.
- Latency:
  - Request sampled at edge E0.
  - With WAIT_CYCLES=W and an immediate rom_ack, ack is high during the cycle after edge E(1+W).
  - Misaligned: ack is high during the cycle after E0.
- Handshake:
  - A master deasserts req, or presents a new addr, at the edge that ends its ack cycle.
  - IDLE samples one cycle after RESP, so a request held high is treated as a new, back-to-back access.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, …
- A request arriving during ACCESS/RESP waits; no request is ever dropped.

Decomposition:
- Shared defines (defines.v):
  - existing `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable;
  - add state encodings `ArbIdle/`ArbAccess/`ArbResp (2 bits).
- Optional sub-module rr_arbiter2: 2-way round-robin grant from req[1:0] and last_grant. The FSM and counter stay in the top module.

Test Plan:
1. Single fetch, W=0: m0_req=1, m0_addr=0x00000004, ROM returns 0x11111111 with ack → m0_ack one cycle, 2 edges after request; m0_data=0x11111111; err=0; m1_ack stays 0.
2. Contention: m0_req and m1_req both held high from reset, 4 accesses → grant_id sequence 0,1,0,1; each ack one cycle; rom_ce low during RESP/IDLE.
3. Wait states, W=3: m1 reads 0x00000010 → rom_ce high for 4 cycles; m1_ack during the cycle after E4; data captured only at cnt==0.
4. Misaligned: m0_addr=0x00000002 → rom_ce never asserted; m0_ack=1 and err=1 one cycle after E0; m0_data=0x00000000.
5. Timeout, TIMEOUT=5: rom_ack tied 0 → ack and err asserted after 5 ACCESS cycles; data=0; next request is served normally.
6. Reset during ACCESS: rst low with W=3 mid-count → all outputs 0 immediately; after release, first grant goes to m0 even if m1 is also requesting.
